// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants, funct codes and the ID/EX pipeline bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN = 32;   // datapath width
    localparam int RAW  = 5;    // register-index width, also the shift-amount width

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Everything ID hands to EX. rs/rt indices travel along so EX can forward.
    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memRead;
        logic [5:0]      funct;
        logic [RAW-1:0]  rd;
        logic [RAW-1:0]  rs;
        logic [RAW-1:0]  rt;
        logic [RAW-1:0]  shamt;
        logic [XLEN-1:0] rsData;
        logic [XLEN-1:0] rtData;
    } idEx_t;

    // All-zero bundle: no write, no load, index 0 everywhere, so nothing forwards.
    localparam idEx_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks EX/MEM, then MEM/WB, then register-file data.
// Latency: combinational.
// Backpressure: none.
// Ports: idx (source register index), regData (registered RF value),
//        exmem*/memwb* (stage write-enable, destination, result), fwdData (selected value).
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]  idx,
    input  logic [XLEN-1:0] regData,
    input  logic            exmemRegWrite,
    input  logic [RAW-1:0]  exmemRd,
    input  logic [XLEN-1:0] exmemResult,
    input  logic            memwbRegWrite,
    input  logic [RAW-1:0]  memwbRd,
    input  logic [XLEN-1:0] memwbResult,
    output logic [XLEN-1:0] fwdData
);

    logic exmemHit;
    logic memwbHit;

    // r0 is hard-wired zero, so a pending write to it must never be forwarded.
    assign exmemHit = exmemRegWrite && (exmemRd != '0) && (exmemRd == idx);
    assign memwbHit = memwbRegWrite && (memwbRd != '0) && (memwbRd == idx);

    // The younger producer (EX/MEM) holds the newer value, so it wins.
    always_comb begin
        fwdData = regData;
        if (exmemHit) begin
            fwdData = exmemResult;
        end else if (memwbHit) begin
            fwdData = memwbResult;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubble, flush, and EX-side forwarding.
// Latency: 1 cycle ID->EX register; forwarded operands combinational on EX contents.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use hazard; flush overrides it.
// Ports: id_* (decoded instruction), flush (branch taken), exmem_*/memwb_* (forwarding sources),
//        stall (hold front end), ex_* (registered controls, shifter dataA/dataB, ALU rs operand).
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic [RAW-1:0]  id_rd,
    input  logic [RAW-1:0]  id_shamt,
    input  logic [5:0]      id_funct,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [RAW-1:0]  exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RAW-1:0]  memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [RAW-1:0]  ex_rd,
    output logic [5:0]      ex_funct,
    output logic [XLEN-1:0] ex_dataA,
    output logic [XLEN-1:0] ex_dataB,
    output logic [XLEN-1:0] ex_rs_fwd
);

    idEx_t exReg;
    idEx_t idBundle;
    logic  hz;
    logic  bubble;

    // A load in EX cannot forward its data in time for a dependent instruction in ID.
    assign hz = exReg.valid && exReg.memRead && (exReg.rd != '0) && id_valid
             && ((exReg.rd == id_rs) || (exReg.rd == id_rt));

    // A flushed instruction is discarded anyway, so there is nothing to hold.
    assign stall  = hz && !flush;
    assign bubble = hz || flush || !id_valid;

    always_comb begin
        idBundle          = BUBBLE;
        idBundle.valid    = id_valid;
        idBundle.regWrite = id_reg_write;
        idBundle.memRead  = id_mem_read;
        idBundle.funct    = id_funct;
        idBundle.rd       = id_rd;
        idBundle.rs       = id_rs;
        idBundle.rt       = id_rt;
        idBundle.shamt    = id_shamt;
        idBundle.rsData   = id_rs_data;
        idBundle.rtData   = id_rt_data;
    end

    // Whole-bundle load or whole-bundle bubble; never a partial update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exReg <= BUBBLE;
        end else if (bubble) begin
            exReg <= BUBBLE;
        end else begin
            exReg <= idBundle;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwdRt (
        .idx           (exReg.rt),
        .regData       (exReg.rtData),
        .exmemRegWrite (exmem_reg_write),
        .exmemRd       (exmem_rd),
        .exmemResult   (exmem_result),
        .memwbRegWrite (memwb_reg_write),
        .memwbRd       (memwb_rd),
        .memwbResult   (memwb_result),
        .fwdData       (ex_dataA)
    );

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwdRs (
        .idx           (exReg.rs),
        .regData       (exReg.rsData),
        .exmemRegWrite (exmem_reg_write),
        .exmemRd       (exmem_rd),
        .exmemResult   (exmem_result),
        .memwbRegWrite (memwb_reg_write),
        .memwbRd       (memwb_rd),
        .memwbResult   (memwb_result),
        .fwdData       (ex_rs_fwd)
    );

    assign ex_valid     = exReg.valid;
    assign ex_reg_write = exReg.regWrite;
    assign ex_mem_read  = exReg.memRead;
    assign ex_rd        = exReg.rd;
    assign ex_funct     = exReg.funct;
    // Shift amount is only RAW bits wide, so the shifter never sees more than 31.
    assign ex_dataB     = {{(XLEN-RAW){1'b0}}, exReg.shamt};

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus the EX-side operand forwarding that feeds the EX-stage shifter/ALU (dataA, dataB, Signal).
- Detects load-use hazards and inserts bubbles.
- Accepts branch flushes.
- Presents forwarded, shift-ready operands to EX every cycle.

Parameters:
- XLEN, 32, datapath width.
- RAW, 5, register-index width; the shift amount is also RAW bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  XLEN  register-file read data.
- id_rs, id_rt, id_rd  in  RAW  register indices.
- id_shamt  in  RAW  instruction shamt field.
- id_funct  in  6  funct code.
- id_reg_write, id_mem_read  in  1  control bits.
- flush  in  1  branch taken; discard the ID instruction.
- exmem_reg_write  in  1  write-enable of the EX/MEM stage.
- exmem_rd  in  RAW  destination of the EX/MEM stage.
- exmem_result  in  XLEN  result of the EX/MEM stage.
- memwb_reg_write  in  1  write-enable of the MEM/WB stage.
- memwb_rd  in  RAW  destination of the MEM/WB stage.
- memwb_result  in  XLEN  result of the MEM/WB stage.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered control bits.
- ex_rd  out  RAW  registered destination index.
- ex_funct  out  6  registered funct; drives shifter Signal.
- ex_dataA  out  XLEN  forwarded rt value; the operand to be shifted.
- ex_dataB  out  XLEN  zero-extended registered shamt; the shift amount.
- ex_rs_fwd  out  XLEN  forwarded rs value for the ALU.

Behaviour:
- Reset (rst_n low, asynchronous): all registered fields are 0, so ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_funct=0, ex_rd=0.
  - ex_dataA and ex_dataB are then derived from zeroed fields: ex_dataB=0; ex_dataA=0 unless forwarding matches r0, which is blocked, so 0.
- Register update: 1-cycle latency. On a clk edge with no bubble, the ID fields load into the EX register.
- Hazard (combinational): hz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((ex_rd==id_rs) | (ex_rd==id_rt)).
- stall = hz & ~flush. A flush overrides the stall because the stalled instruction is discarded anyway.
- Bubble when hz or flush: the EX register loads all-zero (valid=0, reg_write=0, mem_read=0, funct=0, rd=0, data=0).
- A bubble is never merged with a partial load. The bubble lasts exactly one cycle per hazard occurrence; the second cycle re-evaluates hz against the new EX contents.
- Forwarding is combinational on the EX-register contents, applied separately to rs and rt. Priority, highest first:
  1. EX/MEM: exmem_reg_write & exmem_rd!=0 & exmem_rd==idx → exmem_result.
  2. MEM/WB: memwb_reg_write & memwb_rd!=0 & memwb_rd==idx → memwb_result.
  3. Otherwise the registered register-file data.
- Index 0 is never forwarded.
- When ex_valid=0, the forwarding outputs may still update but must be 0 in the bubble case: all bubble indices are 0, so no forwarding source matches.
- ex_dataB = {(XLEN-RAW) zeros, shamt}. Only bits [RAW-1:0] are ever non-zero, so the shifter's 5 stages see shift amounts 0..31 exactly.
- Instructions with id_valid=0 load as bubbles (all-zero) regardless of the other inputs.
- Simultaneous events:
  - flush & hz: bubble, stall=0.
  - Both forwarding sources match: EX/MEM wins.
  - rs==rt: both outputs take the same source.
- Reset asserted mid-stall: stall drops immediately (ex_valid→0 asynchronously) and the register is zero.

Decomposition:
- Shared package cpu_pkg holds:
  - funct constants: FUNCT_SLL=6'b000000, FUNCT_SRL=6'b000010, FUNCT_SRA=6'b000011, ADD/SUB/AND/OR/SLT.
  - XLEN and RAW.
  - A packed struct for the ID/EX bundle, with a BUBBLE constant (all zero).
- One natural sub-module, fwd_mux: one index plus two stage sources in, one forwarded value out. Instantiate it twice (rs, rt).

Test Plan:
- Reset with all inputs non-zero → every output 0 and stall=0. Release reset, then id_funct=6'b000010, id_rt_data=32'hF000_0000, id_shamt=4, id_rt=3 → next cycle ex_funct=6'h02, ex_dataA=32'hF000_0000, ex_dataB=32'd4, ex_valid=1.
- EX holds rd=3 with exmem_reg_write=1, exmem_result=32'h1234, and memwb also rd=3 with result 32'h9999 → ex_dataA=32'h1234 (EX/MEM priority). Drop exmem_reg_write → ex_dataA=32'h9999.
- Forward into r0: exmem_rd=0, exmem_reg_write=1, EX rt=0, registered data 0 → ex_dataA=0.
- Load-use: EX lw rd=5 (mem_read=1), ID id_rs=5 valid → stall=1 that cycle. Next cycle ex_valid=0 and ex_funct=0, stall=0, and the ID instruction loads on the following edge.
- Load-use plus flush in the same cycle → stall=0 and a bubble next cycle. A flush alone with a valid SRL in ID → ex_valid=0, ex_dataB=0.
- Shift amount boundary: id_shamt=31 → ex_dataB=32'd31. id_shamt=0 → ex_dataB=0, and the shifter pass-through gives dataOut=ex_dataA.
